// File: rtl/bin_bcd_dabble.sv
// Purpose: sequential binary (unsigned or two's complement) to BCD converter, shift-and-add-3 ("double dabble").
// Latency: start edge -> ADD; WIDTH ADD/SHIFT pairs; DONE is entered 2*WIDTH edges after the start edge (17th edge counting the start edge as 1).
// Backpressure: none; init is only honoured in IDLE, and results hold until the next completion.
module bin_bcd_dabble #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                sgn,
    input  logic [WIDTH-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic                overflow,
    output logic                busy,
    output logic                done,
    output logic [7:0]          state_ascii
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Working registers: digit chain sits above the binary shift register.
    logic [WIDTH-1:0]    r_sr;
    logic [BW-1:0]       r_dig;
    logic                r_ovf;
    logic                r_sign;
    logic [CW-1:0]       r_cnt;

    // Result registers, only updated on the final shift.
    logic [BW-1:0]       r_bcd;
    logic                r_neg;
    logic                r_overflow;

    // Moore outputs, registered alongside the state.
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_ascii;

    logic                w_neg_in;
    logic [WIDTH-1:0]    w_mag;
    logic [BW-1:0]       w_dig_adj;
    logic [BW+WIDTH-1:0] w_shifted;
    logic                w_last;

    function automatic logic [7:0] f_ascii(input state_t s);
        case (s)
            S_IDLE:  f_ascii = 8'h49; // "I"
            S_ADD:   f_ascii = 8'h41; // "A"
            S_SHIFT: f_ascii = 8'h53; // "S"
            S_DONE:  f_ascii = 8'h44; // "D"
            default: f_ascii = 8'h49;
        endcase
    endfunction

    // Sign/magnitude of the input; the most-negative value negates to itself,
    // which read as unsigned is exactly the required magnitude 2^(WIDTH-1).
    always_comb begin
        w_neg_in = sgn & bin[WIDTH-1];
        w_mag    = w_neg_in ? ((~bin) + WIDTH'(1)) : bin;
    end

    // Add-3 correction: each digit independently, no carry between digits.
    always_comb begin
        w_dig_adj = r_dig;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dig[4*i +: 4] >= 4'd5) begin
                w_dig_adj[4*i +: 4] = r_dig[4*i +: 4] + 4'd3;
            end
        end
    end

    // One-bit left shift of the whole {digits, binary} chain; the top digit bit falls off.
    always_comb begin
        w_shifted = {r_dig, r_sr} << 1;
        w_last    = (r_cnt == CW'(1));
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = init ? S_ADD : S_IDLE;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, working registers, results and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_dig      <= '0;
            r_ovf      <= 1'b0;
            r_sign     <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_neg      <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ascii    <= 8'h49;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_ADD) || (w_next == S_SHIFT);
            r_done  <= (w_next == S_DONE);
            r_ascii <= f_ascii(w_next);
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        r_sr   <= w_mag;
                        r_dig  <= '0;
                        r_ovf  <= 1'b0;
                        r_sign <= w_neg_in;
                        r_cnt  <= CW'(WIDTH);
                    end
                end
                S_ADD: begin
                    r_dig <= w_dig_adj;
                end
                S_SHIFT: begin
                    r_dig <= w_shifted[BW+WIDTH-1:WIDTH];
                    r_sr  <= w_shifted[WIDTH-1:0];
                    r_ovf <= r_ovf | r_dig[BW-1];
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_bcd      <= w_shifted[BW+WIDTH-1:WIDTH];
                        r_neg      <= r_sign;
                        r_overflow <= r_ovf | r_dig[BW-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd         = r_bcd;
    assign neg         = r_neg;
    assign overflow    = r_overflow;
    assign busy        = r_busy;
    assign done        = r_done;
    assign state_ascii = r_ascii;

endmodule

// File: tb/tb_bin_bcd_dabble.sv
// Purpose: scoreboard bench for bin_bcd_dabble, two instances (3 and 2 digits) sharing one stimulus stream.
// Latency: expects done 16 edges after the start edge (17th edge counting the start edge as 1).
// Backpressure: driver only issues a start once the previous conversion has finished.
module tb_bin_bcd_dabble;

    logic        clk;
    logic        rst;
    logic        init;
    logic        sgn;
    logic [7:0]  bin;

    logic [11:0] bcd3;
    logic        neg3, ovf3, busy3, done3;
    logic [7:0]  ascii3;
    logic [7:0]  bcd2;
    logic        neg2, ovf2, busy2, done2;
    logic [7:0]  ascii2;

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        logic        ovf;
        int          start;
    } exp_t;

    exp_t q3[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ndone3 = 0;
    int nb3    = 0;
    int nb2    = 0;
    logic [11:0] last3 = '0;
    logic [7:0]  last2 = '0;

    bin_bcd_dabble #(.WIDTH(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .init(init), .sgn(sgn), .bin(bin),
        .bcd(bcd3), .neg(neg3), .overflow(ovf3), .busy(busy3), .done(done3),
        .state_ascii(ascii3)
    );

    bin_bcd_dabble #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .init(init), .sgn(sgn), .bin(bin),
        .bcd(bcd2), .neg(neg2), .overflow(ovf2), .busy(busy2), .done(done2),
        .state_ascii(ascii2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the decimal value.
    function automatic exp_t model(input logic s, input logic [7:0] b, input int d, input int st);
        exp_t r;
        int v, mag, p;
        v = s ? int'($signed(b)) : int'(b);
        r.neg = (v < 0);
        mag = (v < 0) ? -v : v;
        r.bcd = '0;
        p = 1;
        for (int i = 0; i < d; i++) begin
            r.bcd[4*i +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        r.ovf = (mag >= p);
        r.start = st;
        return r;
    endfunction

    function automatic logic [7:0] exp_ascii(input int k);
        int m;
        m = k % 18;
        if (m < 16) return (m % 2 == 0) ? 8'h41 : 8'h53;
        if (m == 16) return 8'h44;
        return 8'h49;
    endfunction

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin
        if (rst) begin
            nb3 = 0;
            last3 = '0;
        end else begin
            if (busy3) nb3++;
            if (done3) begin
                exp_t e;
                ndone3++;
                if (q3.size() == 0) begin
                    chk("done3_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q3.pop_front();
                    chk("bcd3", 32'(bcd3), 32'(e.bcd));
                    chk("neg3", 32'(neg3), 32'(e.neg));
                    chk("ovf3", 32'(ovf3), 32'(e.ovf));
                    chk("latency3", 32'(cyc - e.start), 32'd16);
                    chk("busy_cycles3", 32'(nb3), 32'd16);
                    last3 = e.bcd;
                end
                nb3 = 0;
            end else if (busy3) begin
                chk("hold3", 32'(bcd3), 32'(last3));
            end
        end
    end

    // Monitor for the 2-digit instance.
    always @(negedge clk) begin
        if (rst) begin
            nb2 = 0;
            last2 = '0;
        end else begin
            if (busy2) nb2++;
            if (done2) begin
                exp_t e;
                if (q2.size() == 0) begin
                    chk("done2_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("bcd2", 32'(bcd2), 32'(e.bcd[7:0]));
                    chk("neg2", 32'(neg2), 32'(e.neg));
                    chk("ovf2", 32'(ovf2), 32'(e.ovf));
                    chk("busy_cycles2", 32'(nb2), 32'd16);
                    last2 = e.bcd[7:0];
                end
                nb2 = 0;
            end else if (busy2) begin
                chk("hold2", 32'(bcd2), 32'(last2));
            end
        end
    end

    // Present one start: init high for exactly one rising edge.
    task automatic start(input logic s, input logic [7:0] b);
        @(negedge clk);
        sgn  = s;
        bin  = b;
        init = 1'b1;
        q3.push_back(model(s, b, 3, cyc + 1));
        q2.push_back(model(s, b, 2, cyc + 1));
        @(negedge clk);
        init = 1'b0;
    endtask

    // Wait for the next done, scrambling bin/sgn meanwhile (they must be ignored).
    task automatic wait_done();
        int n0;
        n0 = ndone3;
        for (int i = 0; i < 40 && ndone3 == n0; i++) begin
            @(negedge clk);
            bin = 8'($urandom);
            sgn = 1'($urandom);
        end
        if (ndone3 == n0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        sgn  = 1'b0;
        bin  = '0;
        #3;
        chk("rst_bcd", 32'(bcd3), 32'd0);
        chk("rst_neg", 32'(neg3), 32'd0);
        chk("rst_ovf", 32'(ovf3), 32'd0);
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_done", 32'(done3), 32'd0);
        chk("rst_ascii", 32'(ascii3), 32'h49);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed values.
        start(1'b0, 8'd255);  wait_done();
        start(1'b1, 8'h80);   wait_done();
        start(1'b1, 8'hFF);   wait_done();
        start(1'b1, 8'h00);   wait_done();
        start(1'b0, 8'd200);  wait_done();
        start(1'b0, 8'd99);   wait_done();
        start(1'b0, 8'd100);  wait_done();

        // A second init plus new bin during the conversion must be ignored
        // (start edge counts as edge 1; this lands on edge 5).
        start(1'b0, 8'd45);
        repeat (3) @(negedge clk);
        init = 1'b1;
        bin  = 8'd77;
        @(negedge clk);
        init = 1'b0;
        wait_done();

        // Reset mid-conversion: immediate IDLE, results cleared, no done.
        start(1'b0, 8'd200);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ascii", 32'(ascii3), 32'h49);
        chk("abort_bcd", 32'(bcd3), 32'd0);
        chk("abort_done", 32'(done3), 32'd0);
        chk("abort_busy", 32'(busy3), 32'd0);
        void'(q3.pop_back());
        void'(q2.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start(1'b0, 8'd9);  wait_done();

        // init held high: back-to-back conversions every 18 cycles.
        @(negedge clk);
        @(negedge clk);
        sgn  = 1'b0;
        bin  = 8'd123;
        init = 1'b1;
        for (int j = 0; j < 3; j++) begin
            q3.push_back(model(1'b0, 8'd123, 3, cyc + 1 + 18*j));
            q2.push_back(model(1'b0, 8'd123, 2, cyc + 1 + 18*j));
        end
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            chk("ascii_seq", 32'(ascii3), 32'(exp_ascii(k)));
        end
        init = 1'b0;
        wait_done();

        // Randomized conversions.
        for (int n = 0; n < 40; n++) begin
            start(1'($urandom), 8'($urandom));
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
